// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: state codes,
// the active-low segment lookup, and the all-dark segment value.
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    // Active-low gfedcba; codes 10..15 light only g (a dash).
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: digit/option inputs from the counter board and the
// multiplexed anode/segment outputs towards the display.
interface seg_scan_driver_if;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        lz_blank_en;
    logic [7:0]  anode;
    logic [7:0]  seg;
    logic        frame_done;

    modport master (
        output enable, digits, dp_mask, lz_blank_en,
        input  anode, seg, frame_done
    );

    modport slave (
        input  enable, digits, dp_mask, lz_blank_en,
        output anode, seg, frame_done
    );
endinterface

// File: rtl/seg_scan_driver_seg_decode.sv
// Combinational digit-to-segment map: value through the lookup, optional
// blanking of a..g, and an active-low decimal point on seg[7].
module seg_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);
    always_comb begin
        seg_o[6:0] = blank_i ? 7'h7F : SEG_LUT[value_i];
        seg_o[7]   = ~dp_i;
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit scan driver: DRIVE/BLANK time-multiplexing with a per-frame
// snapshot of the digits, leading-zero suppression and decimal points.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic             sysclock,
    input  logic             reset,
    seg_scan_driver_if.slave bus
);
    localparam int MAX_CYC = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    dp_q, dp_d;
    logic [7:0]    anode_q, anode_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic [3:0]    dig_zero;
    logic [3:0]    lz_mask;
    logic [3:0]    cur_val;
    logic          cur_blank;
    logic          cur_dp;
    logic [7:0]    dec_seg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        dp_d    = dp_q;
        fd_d    = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    snap_d  = bus.digits;
                    dp_d    = bus.dp_mask;
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        fd_d    = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        // Wrapping back to digit 0 is the only point where new inputs are taken.
                        if (idx_q == 2'd3) begin
                            snap_d = bus.digits;
                            dp_d   = bus.dp_mask;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so anode and seg move together.
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
        assign dig_zero[gi] = (snap_d[4*gi +: 4] == 4'd0);
    end

    assign lz_mask   = {dig_zero[3],
                        dig_zero[3] & dig_zero[2],
                        dig_zero[3] & dig_zero[2] & dig_zero[1],
                        1'b0};
    assign cur_val   = snap_d[{idx_d, 2'b00} +: 4];
    assign cur_blank = bus.lz_blank_en & lz_mask[idx_d];
    assign cur_dp    = dp_d[idx_d];

    seg_decode u_decode (
        .value_i (cur_val),
        .blank_i (cur_blank),
        .dp_i    (cur_dp),
        .seg_o   (dec_seg)
    );

    always_comb begin
        anode_d = 8'hFF;
        seg_d   = SEG_BLANK;
        if (state_d == ST_DRIVE) begin
            anode_d = {4'hF, ~(4'b0001 << idx_d)};
            seg_d   = dec_seg;
        end
    end

    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= 16'h0000;
            dp_q    <= 4'h0;
            anode_q <= 8'hFF;
            seg_q   <= SEG_BLANK;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with TICK_DIV=4, BLANK_CYCLES=2:
// stimulus queues cycle-stamped expected outputs, a negedge monitor checks them.
module tb_seg_scan_driver;

    logic sysclock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [7:0] sg;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    seg_scan_driver_if bus();

    seg_scan_driver #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
        .sysclock (sysclock),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 sysclock = ~sysclock;
    always @(posedge sysclock) cyc <= cyc + 1;

    task automatic chk(input string name, input int at, input logic [7:0] an,
                       input logic [7:0] sg, input logic fd);
        total++;
        if (bus.anode !== an || bus.seg !== sg || bus.frame_done !== fd) begin
            bad++;
            $display("FAIL %s cyc=%0d got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                     name, at, bus.anode, bus.seg, bus.frame_done, an, sg, fd);
        end
    endtask

    task automatic push(input int at, input logic [7:0] an, input logic [7:0] sg, input logic fd);
        exp_t e;
        e.at = at; e.an = an; e.sg = sg; e.fd = fd;
        sb.push_back(e);
    endtask

    // One frame: per digit 4 DRIVE cycles then 2 dark cycles; frame_done on the first dark after digit 3.
    task automatic push_frame(input int start, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input int n);
        logic [7:0] segs [4];
        logic [7:0] an;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int d = 0; d < 4; d++) begin
            an = 8'hFF;
            an[d] = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (d * 6 + k < n) begin
                    if (k < 4) push(start + d * 6 + k, an, segs[d], 1'b0);
                    else       push(start + d * 6 + k, 8'hFF, 8'hFF, (d == 3 && k == 4));
                end
            end
        end
        $display("frame queued start=%0d segs=%h %h %h %h cycles=%0d", start, s0, s1, s2, s3, n);
    endtask

    task automatic push_dark(input int from, input int to);
        for (int c = from; c <= to; c++) push(c, 8'hFF, 8'hFF, 1'b0);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            @(posedge sysclock);
            #1;
            guard++;
        end
    endtask

    always @(negedge sysclock) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_slot cyc=%0d got none want entry@%0d", cyc, sb[0].at);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].at == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("scan", cyc, e.an, e.sg, e.fd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, e, f;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.digits = 16'h4321;
        bus.dp_mask = 4'h0;
        bus.lz_blank_en = 1'b0;
        #1;
        chk("reset_state", cyc, 8'hFF, 8'hFF, 1'b0);
        @(posedge sysclock);
        @(posedge sysclock);
        #3 reset = 1'b0;
        @(posedge sysclock);
        #1;
        push_dark(cyc + 1, cyc + 2);
        wait_until(cyc + 2);

        // Plain scan of 4321, then 9999 applied mid-frame shows only from the next frame.
        bus.enable = 1'b1;
        s = cyc + 1;
        push_frame(s,      8'hF9, 8'hA4, 8'hB0, 8'h99, 24);
        push_frame(s + 24, 8'h90, 8'h90, 8'h90, 8'h90, 24);
        wait_until(s + 7);
        bus.digits = 16'h9999;

        wait_until(s + 30);
        bus.digits = 16'h0050;
        bus.lz_blank_en = 1'b1;
        push_frame(s + 48, 8'hC0, 8'h92, 8'hFF, 8'hFF, 24);

        wait_until(s + 54);
        bus.digits = 16'h0000;
        push_frame(s + 72, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 24);

        wait_until(s + 78);
        bus.digits = 16'h0BCD;
        bus.dp_mask = 4'b0100;
        e = s + 96;
        push_frame(e, 8'hBF, 8'hBF, 8'h3F, 8'hFF, 14);
        push_dark(e + 14, e + 16);

        // Drop enable inside digit 2 DRIVE, then re-enable with fresh digits.
        wait_until(e + 13);
        bus.enable = 1'b0;
        wait_until(e + 16);
        bus.digits = 16'h4321;
        bus.dp_mask = 4'h0;
        bus.lz_blank_en = 1'b0;
        bus.enable = 1'b1;
        f = e + 17;
        push_frame(f, 8'hF9, 8'hA4, 8'hB0, 8'h99, 2);
        push_dark(f + 2, f + 5);

        // Asynchronous reset between clock edges inside digit 0 DRIVE.
        wait_until(f + 2);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", cyc, 8'hFF, 8'hFF, 1'b0);
        bus.digits = 16'h8765;
        wait_until(f + 5);
        push_frame(f + 6, 8'h92, 8'h82, 8'hF8, 8'h80, 24);
        #2 reset = 1'b0;

        wait_until(f + 32);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
